// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
//   uart_state_t  : frame-level FSM states
//   baud_sel_t    : 3-bit baud_select rate codes
//   OVERSAMPLE    : default sample ticks per bit period
//   baud_rate()   : rate code -> baud rate in bit/s
//   baud_divisor(): rounded clk cycles per sample tick for a rate code
package uart_transmitter_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  typedef enum logic [2:0] {
    BAUD_300    = 3'd0,
    BAUD_1200   = 3'd1,
    BAUD_4800   = 3'd2,
    BAUD_9600   = 3'd3,
    BAUD_19200  = 3'd4,
    BAUD_38400  = 3'd5,
    BAUD_57600  = 3'd6,
    BAUD_115200 = 3'd7
  } baud_sel_t;

  function automatic int unsigned baud_rate(input logic [2:0] code);
    case (baud_sel_t'(code))
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // round(clk_hz / (oversample * baud)) using integer arithmetic
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input int unsigned oversample,
                                               input logic [2:0]  code);
    int unsigned den;
    den = oversample * baud_rate(code);
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_tick.sv
// uart_baud_tick: sample_enable generator.
//   clk, reset     : system clock, async active-high reset
//   baud_select    : rate code selecting the divisor
//   restart        : synchronous restart; counter returns to zero
//   sample_enable  : one-cycle pulse every divisor clk cycles
module uart_baud_tick #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = uart_transmitter_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       restart,
  output logic       sample_enable
);
  import uart_transmitter_pkg::*;

  localparam int unsigned MAX_DIV = baud_divisor(CLK_HZ, OVERSAMPLE, 3'd0);
  localparam int unsigned DIV_W   = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;

  function automatic logic [DIV_W-1:0] last_of(input logic [2:0] code);
    return DIV_W'(baud_divisor(CLK_HZ, OVERSAMPLE, code) - 1);
  endfunction

  // Divisors folded to constants so no run-time divider is built
  localparam logic [DIV_W-1:0] DIV_LAST [8] = '{
    last_of(3'd0), last_of(3'd1), last_of(3'd2), last_of(3'd3),
    last_of(3'd4), last_of(3'd5), last_of(3'd6), last_of(3'd7)
  };

  logic [DIV_W-1:0] div_cnt;

  assign sample_enable = (div_cnt == DIV_LAST[baud_select]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (restart || sample_enable) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8E1 serial transmitter (start, 8 data LSB first,
// even parity, stop).
//   clk, reset   : system clock, async active-high reset
//   baud_select  : rate code, latched when a frame is accepted
//   Tx_EN        : enable; dropping it aborts any frame in flight
//   Tx_WR        : write strobe, accepted only when idle and enabled
//   Tx_DATA      : byte to send, latched on accept
//   Tx_D         : registered serial line, idle high
//   Tx_BUSY      : registered, high from accept to end of stop bit
module uart_transmitter #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = uart_transmitter_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_D,
  output logic       Tx_BUSY
);
  import uart_transmitter_pkg::*;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  idx_q, idx_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic [2:0]  code_q, code_d;
  logic        restart;
  logic        sample_enable;
  logic        bit_done;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (code_q),
    .restart       (restart),
    .sample_enable (sample_enable)
  );

  assign bit_done = sample_enable && (tick_q == TICK_LAST);

  // Tx_D / Tx_BUSY are computed from the next state so both are registered
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    code_d   = code_q;
    restart  = 1'b0;

    if (bit_done) begin
      tick_d = '0;
    end else if (sample_enable) begin
      tick_d = tick_q + 4'd1;
    end

    if (!Tx_EN) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      idx_d   = '0;
      txd_d   = 1'b1;
      busy_d  = 1'b0;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          idx_d  = '0;
          txd_d  = 1'b1;
          busy_d = 1'b0;
          if (Tx_WR) begin
            state_d  = ST_START;
            shift_d  = Tx_DATA;
            parity_d = ^Tx_DATA;
            code_d   = baud_select;
            restart  = 1'b1;
            txd_d    = 1'b0;
            busy_d   = 1'b1;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_d = ST_DATA;
            txd_d   = shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift_d = shift_q >> 1;
            if (idx_q == 3'd7) begin
              state_d = ST_PARITY;
              idx_d   = '0;
              txd_d   = parity_q;
            end else begin
              idx_d = idx_q + 3'd1;
              txd_d = shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
          idx_d   = '0;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tick_q   <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      code_q   <= code_d;
    end
  end

  assign Tx_D    = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, system clock frequency used to derive the baud divisors.
REQ-002 Parameter: OVERSAMPLE, default 16, sample_enable ticks per bit period.
REQ-003 Ports: clk  input  1  system clock, rising-edge.
REQ-004 Ports: reset  input  1  asynchronous, active-high reset.
REQ-005 Ports: baud_select  input  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
REQ-006 Ports: Tx_EN  input  1  module enable.
REQ-007 Ports: Tx_WR  input  1  single-cycle write strobe.
REQ-008 Ports: Tx_DATA  input  8  byte to send, sampled on an accepted Tx_WR.
REQ-009 Ports: Tx_D  output  1  serial line, idle high, registered.
REQ-010 Ports: Tx_BUSY  output  1  high from accept until the stop bit completes, registered.

Function
REQ-011 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (1); 11 bits total.
REQ-012 Divisor SHALL be round(CLK_HZ/(OVERSAMPLE*baud)); at 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
REQ-013 Each bit SHALL last exactly OVERSAMPLE sample_enable ticks, i.e. OVERSAMPLE*divisor clk cycles (432 at 115200).
REQ-014 The tick generator SHALL restart on frame accept, so the start-bit length is exact.
REQ-015 States: IDLE, START, DATA, PARITY, STOP; 4-bit tick counter and 3-bit bit index.
REQ-016 IDLE→START SHALL occur when Tx_WR=1 and Tx_EN=1; Tx_DATA is latched into a shift register and parity is computed at accept.
REQ-017 Latency: for Tx_WR at cycle n, Tx_D=0 and Tx_BUSY=1 SHALL hold at cycle n+1.
REQ-018 START→DATA, DATA(index 7)→PARITY, PARITY→STOP and STOP→IDLE SHALL occur on the 16th tick of the current bit; within DATA, the index increments on every 16th tick.
REQ-019 Tx_BUSY SHALL fall in the cycle the FSM enters IDLE; a Tx_WR in that same cycle or later SHALL be accepted.
REQ-020 Tx_WR while Tx_BUSY=1 SHALL be ignored; the in-flight frame and latched data are unaffected.
REQ-021 Tx_WR with Tx_EN=0 SHALL be ignored.
REQ-022 Tx_EN deasserted mid-frame SHALL abort: next cycle Tx_D=1, Tx_BUSY=0, state IDLE, counters cleared.
REQ-023 A baud_select change mid-frame SHALL take effect at the next accept only; the select code is latched at accept.
REQ-024 Changes on Tx_DATA after accept SHALL NOT affect the frame.
REQ-025 Tx_D SHALL be 1 in IDLE and whenever the FSM is in any unused encoding.
REQ-026 Unused FSM encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 On reset the block SHALL enter IDLE with Tx_D=1, Tx_BUSY=0, and the shift register, counters and tick generator cleared.
REQ-028 Reset asserted mid-frame SHALL abort immediately and asynchronously; Tx_D goes to 1 with no glitch to 0.
REQ-029 After reset release, the first Tx_WR SHALL be accepted in the cycle it is presented.

Structure
REQ-030 A shared package SHALL hold the state enum, the baud_select codes, OVERSAMPLE, and the divisor table function, shared with the receiver.
REQ-031 One sub-module, uart_baud_tick, SHALL generate sample_enable from baud_select, with a synchronous restart input.

Verification
REQ-032 Reset, then Tx_WR with Tx_DATA=8'hA5 at 115200 → Tx_D sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 432 cycles; Tx_BUSY high for 4752 cycles.
REQ-033 Send 8'h07 at 9600 → parity bit=1, bit period 5216 cycles; the frame decoded by the existing receiver shows Rx_VALID=1, Rx_DATA=8'h07, no errors.
REQ-034 Tx_WR with 8'h3C in the cycle after accepting 8'hFF → 8'h3C ignored; exactly one frame (8'hFF, parity 0) is sent.
REQ-035 Back-to-back: Tx_WR in the cycle Tx_BUSY falls → the second start bit follows the first stop bit with no idle gap.
REQ-036 Tx_EN dropped during DATA bit 3 → Tx_D=1 and Tx_BUSY=0 the next cycle; a later Tx_WR sends a complete fresh frame.
REQ-037 Reset pulsed mid-PARITY → Tx_D=1 and Tx_BUSY=0 asynchronously; no further line activity until a new Tx_WR.
